// File: rtl/wb_pkg.sv
// ---------------------------------------------------------------------------
// wb_pkg
// Shared definitions for the writeback stage: default widths, the
// architectural zero register, the buffered MD result layout and a
// pointer-width helper.
// ---------------------------------------------------------------------------
package wb_pkg;

   localparam int DATA_BITS_DEF  = 32;
   localparam int ADDR_BITS_DEF  = 5;
   localparam int FIFO_DEPTH_DEF = 2;

   // Writes to register 0 are discarded everywhere in this stage.
   localparam int REG_ZERO = 0;

   // Buffered MD result at default widths. wb_fifo declares the same
   // layout locally so that non-default widths still work.
   typedef struct packed {
      logic                     live;
      logic [ADDR_BITS_DEF-1:0] addr;
      logic [DATA_BITS_DEF-1:0] data;
   } wb_entry_t;

   // Pointer width for a circular buffer; a depth of 1 still needs one bit.
   function automatic int ptr_bits(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// ---------------------------------------------------------------------------
// wb_fifo
// Circular buffer of {live, addr, data} entries holding MD results until the
// register-file write port is free. Entries can be killed in place by
// address (squash) without being removed; dead entries are later popped by
// the parent without producing a write.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   push_i/_addr/_data  enqueue an entry with live=1 (ignored when full)
//   pop_i               remove the head entry (ignored when empty)
//   squash_i/_addr_i    clear live on every stored entry with this address
//   count_o             number of occupied slots, 0..FIFO_DEPTH
//   head_live_o/addr/data  head entry (live is 0 when empty)
//   live_o              per-slot live bits
//   live_addr_o         per-slot addresses, slot i at [i*ADDR_BITS +: ADDR_BITS]
// ---------------------------------------------------------------------------
module wb_fifo
   import wb_pkg::*;
#(
   parameter int DATA_BITS  = DATA_BITS_DEF,
   parameter int ADDR_BITS  = ADDR_BITS_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
   localparam int CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            push_i,
   input  logic [ADDR_BITS-1:0]            push_addr_i,
   input  logic [DATA_BITS-1:0]            push_data_i,
   input  logic                            pop_i,
   input  logic                            squash_i,
   input  logic [ADDR_BITS-1:0]            squash_addr_i,
   output logic [CNT_W-1:0]                count_o,
   output logic                            head_live_o,
   output logic [ADDR_BITS-1:0]            head_addr_o,
   output logic [DATA_BITS-1:0]            head_data_o,
   output logic [FIFO_DEPTH-1:0]           live_o,
   output logic [FIFO_DEPTH*ADDR_BITS-1:0] live_addr_o
);

   localparam int PTR_W = ptr_bits(FIFO_DEPTH);

   typedef struct packed {
      logic                 live;
      logic [ADDR_BITS-1:0] addr;
      logic [DATA_BITS-1:0] data;
   } entry_t;

   entry_t [FIFO_DEPTH-1:0] mem_q, mem_d;
   logic   [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic   [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic   [CNT_W-1:0]      count_q, count_d;
   logic                    push_ok, pop_ok;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign push_ok = push_i && (count_q < CNT_W'(FIFO_DEPTH));
   assign pop_ok  = pop_i  && (count_q != '0);

   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;

      // Squash looks only at stored entries; an entry pushed this cycle is
      // written after the loop and therefore survives.
      if (squash_i) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (mem_q[i].addr == squash_addr_i) mem_d[i].live = 1'b0;
         end
      end

      // Popped slots are left dead so that unoccupied slots never look live.
      if (pop_ok) begin
         mem_d[rd_ptr_q].live = 1'b0;
         rd_ptr_d             = next_ptr(rd_ptr_q);
      end

      if (push_ok) begin
         mem_d[wr_ptr_q].live = 1'b1;
         mem_d[wr_ptr_q].addr = push_addr_i;
         mem_d[wr_ptr_q].data = push_data_i;
         wr_ptr_d             = next_ptr(wr_ptr_q);
      end

      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q    <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   assign count_o     = count_q;
   assign head_live_o = (count_q != '0) && mem_q[rd_ptr_q].live;
   assign head_addr_o = mem_q[rd_ptr_q].addr;
   assign head_data_o = mem_q[rd_ptr_q].data;

   always_comb begin
      live_o      = '0;
      live_addr_o = '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         live_o[i]                             = mem_q[i].live;
         live_addr_o[i*ADDR_BITS +: ADDR_BITS] = mem_q[i].addr;
      end
   end

endmodule

// File: rtl/writeback_arbiter.sv
// ---------------------------------------------------------------------------
// writeback_arbiter
// Feeds the register file's single write port. The ALU/load stream cannot
// stall and always wins; MD results queue in wb_fifo and drain in free
// cycles. An ALU write squashes older buffered MD results to the same
// register so the later ALU value is never overwritten (WAW).
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   AluValid/AluAddress/AluData     ALU/load result (address 0 = no result)
//   MdValid/MdReady/MdAddress/MdData  MD result handshake
//   WriteEnable/DAddress/DData      registered register-file write
//   PendingMask                     one bit per register with a live MD entry
// ---------------------------------------------------------------------------
module writeback_arbiter
   import wb_pkg::*;
#(
   parameter int DATA_BITS  = DATA_BITS_DEF,
   parameter int ADDR_BITS  = ADDR_BITS_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        AluValid,
   input  logic [ADDR_BITS-1:0]        AluAddress,
   input  logic [DATA_BITS-1:0]        AluData,
   input  logic                        MdValid,
   output logic                        MdReady,
   input  logic [ADDR_BITS-1:0]        MdAddress,
   input  logic [DATA_BITS-1:0]        MdData,
   output logic                        WriteEnable,
   output logic [ADDR_BITS-1:0]        DAddress,
   output logic [DATA_BITS-1:0]        DData,
   output logic [(1<<ADDR_BITS)-1:0]   PendingMask
);

   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   logic                            alu_wr;
   logic                            md_push;
   logic                            fifo_pop;
   logic [CNT_W-1:0]                fifo_count;
   logic                            head_live;
   logic [ADDR_BITS-1:0]            head_addr;
   logic [DATA_BITS-1:0]            head_data;
   logic [FIFO_DEPTH-1:0]           live_vec;
   logic [FIFO_DEPTH*ADDR_BITS-1:0] live_addr_vec;

   logic                 we_q, we_d;
   logic [ADDR_BITS-1:0] addr_q, addr_d;
   logic [DATA_BITS-1:0] data_q, data_d;

   // Ready comes from the registered count only: a full buffer refuses a
   // result even in a cycle where it also pops.
   assign MdReady = (fifo_count < CNT_W'(FIFO_DEPTH));

   // Zero-address results are architecturally invisible. An MD result to r0
   // still completes the handshake, it just never enters the buffer.
   assign alu_wr  = AluValid && (AluAddress != ADDR_BITS'(REG_ZERO));
   assign md_push = MdValid && MdReady && (MdAddress != ADDR_BITS'(REG_ZERO));

   // A dead head is discarded in any cycle; a live head only when the ALU
   // leaves the write port free.
   assign fifo_pop = (fifo_count != '0) && (!head_live || !alu_wr);

   wb_fifo #(
      .DATA_BITS  (DATA_BITS),
      .ADDR_BITS  (ADDR_BITS),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk           (clk),
      .rst_n         (rst_n),
      .push_i        (md_push),
      .push_addr_i   (MdAddress),
      .push_data_i   (MdData),
      .pop_i         (fifo_pop),
      .squash_i      (alu_wr),
      .squash_addr_i (AluAddress),
      .count_o       (fifo_count),
      .head_live_o   (head_live),
      .head_addr_o   (head_addr),
      .head_data_o   (head_data),
      .live_o        (live_vec),
      .live_addr_o   (live_addr_vec)
   );

   always_comb begin
      we_d   = 1'b0;
      addr_d = addr_q;
      data_d = data_q;
      if (alu_wr) begin
         we_d   = 1'b1;
         addr_d = AluAddress;
         data_d = AluData;
      end else if (head_live) begin
         we_d   = 1'b1;
         addr_d = head_addr;
         data_d = head_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q   <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
      end else begin
         we_q   <= we_d;
         addr_q <= addr_d;
         data_q <= data_d;
      end
   end

   assign WriteEnable = we_q;
   assign DAddress    = addr_q;
   assign DData       = data_q;

   // Pending registers come purely from buffer state, so decode sees no
   // combinational path from this cycle's inputs.
   always_comb begin
      PendingMask = '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         if (live_vec[i]) PendingMask[live_addr_vec[i*ADDR_BITS +: ADDR_BITS]] = 1'b1;
      end
   end

endmodule

// File: tb/tb_writeback_arbiter.sv
module tb_writeback_arbiter;

   localparam int DB    = 32;
   localparam int AB    = 5;
   localparam int DEPTH = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          AluValid, MdValid;
   logic [AB-1:0] AluAddress, MdAddress;
   logic [DB-1:0] AluData, MdData;
   logic          MdReady, WriteEnable;
   logic [AB-1:0] DAddress;
   logic [DB-1:0] DData;
   logic [31:0]   PendingMask;

   writeback_arbiter #(.DATA_BITS(DB), .ADDR_BITS(AB), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .AluValid(AluValid), .AluAddress(AluAddress), .AluData(AluData),
      .MdValid(MdValid), .MdReady(MdReady), .MdAddress(MdAddress), .MdData(MdData),
      .WriteEnable(WriteEnable), .DAddress(DAddress), .DData(DData),
      .PendingMask(PendingMask)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input bit av, input logic [AB-1:0] aa, input logic [DB-1:0] ad,
                        input bit mv, input logic [AB-1:0] ma, input logic [DB-1:0] md);
      AluValid = av; AluAddress = aa; AluData = ad;
      MdValid  = mv; MdAddress  = ma; MdData  = md;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      bit          av; logic [AB-1:0] aa; logic [DB-1:0] ad;
      bit          mv; logic [AB-1:0] ma; logic [DB-1:0] md;
      bit          e_we; logic [AB-1:0] e_a; logic [DB-1:0] e_d;
      logic [31:0] e_mask; bit e_rdy;
   } vec_t;
   vec_t vecs[$];

   task automatic add(input bit av, input int aa, input int ad, input bit mv, input int ma, input int md,
                      input bit we, input int ea, input int ed, input logic [31:0] mask, input bit rdy);
      vec_t v;
      v.av = av; v.aa = AB'(aa); v.ad = DB'(ad);
      v.mv = mv; v.ma = AB'(ma); v.md = DB'(md);
      v.e_we = we; v.e_a = AB'(ea); v.e_d = DB'(ed); v.e_mask = mask; v.e_rdy = rdy;
      vecs.push_back(v);
   endtask

   // ---------------- reference model ----------------
   typedef struct { bit live; logic [AB-1:0] addr; logic [DB-1:0] data; } ent_t;
   ent_t          mq[$];
   bit            m_we;
   logic [AB-1:0] m_a;
   logic [DB-1:0] m_d;

   task automatic model_step(input bit av, input logic [AB-1:0] aa, input logic [DB-1:0] ad,
                             input bit mv, input logic [AB-1:0] ma, input logic [DB-1:0] md);
      bit acc;
      bit aw;
      ent_t e;
      acc  = mv && (mq.size() < DEPTH);
      aw   = av && (aa != 0);
      m_we = 0;
      if (aw) begin m_we = 1; m_a = aa; m_d = ad; end
      if (mq.size() > 0) begin
         if (!mq[0].live) mq.delete(0);
         else if (!aw) begin
            m_we = 1; m_a = mq[0].addr; m_d = mq[0].data;
            mq.delete(0);
         end
      end
      if (aw) foreach (mq[i]) if (mq[i].addr == aa) mq[i].live = 0;
      if (acc && ma != 0) begin
         e.live = 1; e.addr = ma; e.data = md;
         mq.push_back(e);
      end
   endtask

   function automatic logic [31:0] model_mask();
      logic [31:0] m = '0;
      foreach (mq[i]) if (mq[i].live) m[mq[i].addr] = 1'b1;
      return m;
   endfunction

   initial begin
      drive(0, 0, 0, 0, 0, 0);

      // Test plan sequences (state carries from row to row).
      //   av aa  ad        mv ma md        we ea ed        mask  rdy
      add(1, 5, 'h1234,   0, 0, 0,        1, 5, 'h1234,   32'h0,  1);
      add(0, 0, 0,        0, 0, 0,        0, 5, 'h1234,   32'h0,  1);
      add(0, 0, 0,        1, 7, 'hAAAA,   0, 5, 'h1234,   32'h80, 1);
      add(0, 0, 0,        0, 0, 0,        1, 7, 'hAAAA,   32'h0,  1);
      add(0, 0, 0,        0, 0, 0,        0, 7, 'hAAAA,   32'h0,  1);
      add(1, 9, 'h9,      1, 3, 'h33,     1, 9, 'h9,      32'h8,  1);
      add(1, 9, 'h9,      1, 4, 'h44,     1, 9, 'h9,      32'h18, 0);
      add(1, 9, 'h9,      1, 8, 'h88,     1, 9, 'h9,      32'h18, 0);
      add(0, 0, 0,        0, 0, 0,        1, 3, 'h33,     32'h10, 1);
      add(0, 0, 0,        0, 0, 0,        1, 4, 'h44,     32'h0,  1);
      add(0, 0, 0,        1, 6, 'h66,     0, 4, 'h44,     32'h40, 1);
      add(1, 6, 'h55,     0, 0, 0,        1, 6, 'h55,     32'h0,  1);
      add(0, 0, 0,        0, 0, 0,        0, 6, 'h55,     32'h0,  1);
      add(1, 0, 'hBEEF,   1, 0, 'h1,      0, 6, 'h55,     32'h0,  1);
      add(0, 0, 0,        0, 0, 0,        0, 6, 'h55,     32'h0,  1);
      add(1, 2, 'h22,     1, 2, 'h202,    1, 2, 'h22,     32'h4,  1);
      add(0, 0, 0,        0, 0, 0,        1, 2, 'h202,    32'h0,  1);
      add(0, 0, 0,        1, 1, 'h11,     0, 2, 'h202,    32'h2,  1);
      add(1, 0, 'hFFFF,   0, 0, 0,        1, 1, 'h11,     32'h0,  1);

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("reset_we",   WriteEnable, 0);
      chk("reset_addr", DAddress,    0);
      chk("reset_data", DData,       0);
      chk("reset_mask", PendingMask, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("reset_rdy",  MdReady,     1);

      foreach (vecs[i]) begin
         drive(vecs[i].av, vecs[i].aa, vecs[i].ad, vecs[i].mv, vecs[i].ma, vecs[i].md);
         @(posedge clk); #1;
         chk($sformatf("vec%0d_we", i),   WriteEnable, vecs[i].e_we);
         chk($sformatf("vec%0d_addr", i), DAddress,    vecs[i].e_a);
         chk($sformatf("vec%0d_data", i), DData,       vecs[i].e_d);
         chk($sformatf("vec%0d_mask", i), PendingMask, vecs[i].e_mask);
         chk($sformatf("vec%0d_rdy", i),  MdReady,     vecs[i].e_rdy);
      end

      // Reset mid-operation with two entries buffered.
      drive(1, 9, 'h9, 1, 3, 'h33);
      @(posedge clk); #1;
      drive(1, 9, 'h9, 1, 4, 'h44);
      @(posedge clk); #1;
      chk("midrst_pre_mask", PendingMask, 32'h18);
      chk("midrst_pre_rdy",  MdReady,     0);
      drive(0, 0, 0, 0, 0, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_we",   WriteEnable, 0);
      chk("midrst_addr", DAddress,    0);
      chk("midrst_data", DData,       0);
      chk("midrst_mask", PendingMask, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         chk("postrst_we",   WriteEnable, 0);
         chk("postrst_mask", PendingMask, 0);
         chk("postrst_rdy",  MdReady,     1);
      end

      // Randomized traffic against the model (DUT state is clean after reset
      // and the idle cycles above).
      mq.delete();
      m_we = 0; m_a = '0; m_d = '0;
      for (int c = 0; c < 600; c++) begin
         bit          av, mv;
         logic [AB-1:0] aa, ma;
         logic [DB-1:0] ad, md;
         av = ($urandom_range(0, 99) < 55);
         mv = ($urandom_range(0, 99) < 60);
         aa = AB'($urandom_range(0, 7));
         ma = AB'($urandom_range(0, 7));
         ad = $urandom();
         md = $urandom();
         chk("rnd_rdy", MdReady, (mq.size() < DEPTH));
         drive(av, aa, ad, mv, ma, md);
         model_step(av, aa, ad, mv, ma, md);
         @(posedge clk); #1;
         chk("rnd_we",   WriteEnable, m_we);
         chk("rnd_addr", DAddress,    m_a);
         chk("rnd_data", DData,       m_d);
         chk("rnd_mask", PendingMask, model_mask());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
